alu_logic_sequencer: RTL and testbench
======================================

Name: alu_logic_sequencer

Overview:
- Initiator side of the 16-bit ALU logic unit interface.
- Accepts instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives registered operands and a 4-bit function select to the logic unit, captures its combinational result, writes it back and reports completion.
- Sits between the level-4 instruction source and the logic unit.

Parameters:
- NREGS, 8, register file depth (fixed at 8; 3-bit register addresses).
- W, 16, datapath width (must match the logic unit).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction word.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- lu_a  out  16  operand A to logic unit.
- lu_b  out  16  operand B to logic unit.
- lu_sel  out  4  function select to logic unit.
- lu_result  in  16  combinational result from logic unit.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  16  value written back.
- res_rd  out  3  destination register written.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational register-file read of dbg_addr.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE; all registers=0; lu_a, lu_b, res_data=0; lu_sel=0; res_rd=0; res_valid=0.
- Instruction format, instr[15]=0 (ALU op): [14:12] rd, [11:8] sel, [7:5] ra, [4:2] rb, [1:0] ignored.
- Instruction format, instr[15]=1 (load immediate): [14:12] rd, [7:0] imm8 zero-extended to 16; [11:8] ignored.
- Handshake: transfer occurs on a clock edge with instr_valid && instr_ready. instr_ready = (state==IDLE), derived from state only, with no dependence on instr_valid.
- FSM transitions:
  - IDLE -> ISSUE on an ALU-op transfer. Capture rd, and load lu_a=rf[ra], lu_b=rf[rb], lu_sel=sel.
  - IDLE -> WB on a load-immediate transfer. Capture rd and imm into the result register.
  - ISSUE -> CAPTURE unconditionally; the logic unit output settles during ISSUE. result register <= lu_result at the end of ISSUE.
  - CAPTURE -> WB unconditionally.
  - WB -> IDLE. rf[rd] <= result; res_valid=1 for this cycle only; res_data=result; res_rd=rd.
- Latency, counted from the transfer edge (cycle 0):
  - ALU op: res_valid high in cycle 3; instruction throughput 1 per 4 cycles.
  - Load immediate: res_valid in cycle 1; throughput 1 per 2 cycles.
- Holding values: lu_a, lu_b and lu_sel hold their last values outside ISSUE/CAPTURE (no glitching to 0). res_data and res_rd hold after the pulse.
- Same register as source and destination (ra==rd or rb==rd): operands are sampled at issue, so the old value is used. There is no forwarding hazard because execution is serial.
- dbg_data during WB shows the pre-write value; it updates after the edge.
- instr_valid while not IDLE: ignored and not consumed; the source must hold it.
- Reset mid-operation aborts the instruction: no res_valid, and the register file is cleared.
- Logic unit select encoding (the sequencer passes sel through unchanged; the encoding lives in the package):
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 16'h0000; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B.
  - 8 ~A|B; 9 ~(A^B); 10 B; 11 A&B; 12 16'h0001; 13 A|~B; 14 A|B; 15 A.

Decomposition:
- Shared package alu_pkg:
  - lu_sel_e enum for the 16 encodings above.
  - Instruction field position constants.
  - state_e {IDLE, ISSUE, CAPTURE, WB}.
  - W=16.
- Sub-module alu_regfile: 8x16, one write port, two combinational read ports (operands) plus the debug read port, async reset to zero.
- The FSM stays in the top module. The logic unit is instantiated by the integrating level, not inside this block.

Test Plan:
- Reset then dbg_addr sweep 0..7 -> dbg_data=16'h0000 for every address; instr_ready=1.
- Load immediate r1=8'hA5 and r2=8'h3C -> each res_valid one cycle after its transfer, res_data 16'h00A5 / 16'h003C, res_rd 1 / 2.
- ALU op rd=3, ra=1, rb=2, sel=6 with the reference logic unit attached -> lu_a=16'h00A5, lu_b=16'h003C, lu_sel=6 in ISSUE; res_valid in cycle 3 with res_data=16'h0099; dbg r3=16'h0099.
- sel=12 and sel=3 on any operands -> res_data 16'h0001 and 16'h0000 respectively; sel=0 on r1 -> 16'hFF5A.
- ALU op rd=1, ra=1, rb=1, sel=0, then a second instr_valid held during ISSUE -> r1 becomes ~old value; instr_ready=0 for 3 cycles; the second instruction is accepted only on return to IDLE.
- Assert rst_n low during CAPTURE -> no res_valid, state=IDLE, all registers 0, outputs at reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU logic sequencer and its register file.
package alu_pkg;

  localparam int W     = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  // Instruction field positions
  localparam int OP_BIT  = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 12;
  localparam int SEL_MSB = 11;
  localparam int SEL_LSB = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 5;
  localparam int RB_MSB  = 4;
  localparam int RB_LSB  = 2;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    LU_NOT_A      = 4'd0,
    LU_NOR        = 4'd1,
    LU_NOTA_AND_B = 4'd2,
    LU_ZERO       = 4'd3,
    LU_NAND       = 4'd4,
    LU_NOT_B      = 4'd5,
    LU_XOR        = 4'd6,
    LU_A_AND_NOTB = 4'd7,
    LU_NOTA_OR_B  = 4'd8,
    LU_XNOR       = 4'd9,
    LU_B          = 4'd10,
    LU_AND        = 4'd11,
    LU_ONE        = 4'd12,
    LU_A_OR_NOTB  = 4'd13,
    LU_OR         = 4'd14,
    LU_A          = 4'd15
  } lu_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    WB      = 2'd3
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: one write port, two operand read ports and a debug read port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b,
  output logic [W-1:0]  o_dbg_data
);

  logic [W-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_logic_sequencer.sv
// Initiator side of the 16-bit logic unit: decodes instructions, issues operands,
// captures the unit's result and writes it back to the register file.
//
// state   | meaning
// IDLE    | ready for an instruction
// ISSUE   | operands driven, logic unit output settling
// CAPTURE | result captured, completion being prepared
// WB      | result written to rf[rd], res_valid high
module alu_logic_sequencer
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i_instr,
  input  logic          i_instr_valid,
  output logic          o_instr_ready,
  output logic [W-1:0]  o_lu_a,
  output logic [W-1:0]  o_lu_b,
  output logic [3:0]    o_lu_sel,
  input  logic [W-1:0]  i_lu_result,
  output logic          o_res_valid,
  output logic [W-1:0]  o_res_data,
  output logic [AW-1:0] o_res_rd,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [W-1:0]  o_dbg_data
);

  state_e        r_state;
  logic [AW-1:0] r_rd;
  logic [W-1:0]  r_result;
  logic [W-1:0]  r_lu_a;
  logic [W-1:0]  r_lu_b;
  lu_sel_e       r_lu_sel;
  logic          r_res_valid;
  logic [W-1:0]  r_res_data;
  logic [AW-1:0] r_res_rd;

  logic [W-1:0]  w_rdata_a;
  logic [W-1:0]  w_rdata_b;
  logic [AW-1:0] w_rd;
  logic [W-1:0]  w_imm;
  logic          w_is_li;

  assign w_rd    = i_instr[RD_MSB:RD_LSB];
  assign w_imm   = {8'h00, i_instr[IMM_MSB:IMM_LSB]};
  assign w_is_li = i_instr[OP_BIT];

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (r_state == WB),
    .i_waddr    (r_rd),
    .i_wdata    (r_result),
    .i_raddr_a  (i_instr[RA_MSB:RA_LSB]),
    .i_raddr_b  (i_instr[RB_MSB:RB_LSB]),
    .i_dbg_addr (i_dbg_addr),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (o_dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd        <= '0;
      r_result    <= '0;
      r_lu_a      <= '0;
      r_lu_b      <= '0;
      r_lu_sel    <= LU_NOT_A;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_instr_valid) begin
            r_rd <= w_rd;
            if (w_is_li) begin
              // Load immediate skips the logic unit and completes next cycle
              r_result    <= w_imm;
              r_res_valid <= 1'b1;
              r_res_data  <= w_imm;
              r_res_rd    <= w_rd;
              r_state     <= WB;
            end else begin
              r_lu_a   <= w_rdata_a;
              r_lu_b   <= w_rdata_b;
              r_lu_sel <= lu_sel_e'(i_instr[SEL_MSB:SEL_LSB]);
              r_state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_result <= i_lu_result;
          r_state  <= CAPTURE;
        end
        CAPTURE: begin
          r_res_valid <= 1'b1;
          r_res_data  <= r_result;
          r_res_rd    <= r_rd;
          r_state     <= WB;
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_instr_ready = (r_state == IDLE);
  assign o_lu_a        = r_lu_a;
  assign o_lu_b        = r_lu_b;
  assign o_lu_sel      = r_lu_sel;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_res_rd      = r_res_rd;

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Self-checking bench for alu_logic_sequencer with a reference logic unit attached.
module tb_alu_logic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [15:0] o_lu_a;
  logic [15:0] o_lu_b;
  logic [3:0]  o_lu_sel;
  logic [15:0] i_lu_result;
  logic        o_res_valid;
  logic [15:0] o_res_data;
  logic [2:0]  o_res_rd;
  logic [2:0]  i_dbg_addr;
  logic [15:0] o_dbg_data;

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] model_rf [8];

  always #5 clk = ~clk;

  alu_logic_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_instr       (i_instr),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .o_lu_a        (o_lu_a),
    .o_lu_b        (o_lu_b),
    .o_lu_sel      (o_lu_sel),
    .i_lu_result   (i_lu_result),
    .o_res_valid   (o_res_valid),
    .o_res_data    (o_res_data),
    .o_res_rd      (o_res_rd),
    .i_dbg_addr    (i_dbg_addr),
    .o_dbg_data    (o_dbg_data)
  );

  function automatic logic [15:0] lu_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s);
    case (s)
      4'd0:    return ~a;
      4'd1:    return ~(a | b);
      4'd2:    return ~a & b;
      4'd3:    return 16'h0000;
      4'd4:    return ~(a & b);
      4'd5:    return ~b;
      4'd6:    return a ^ b;
      4'd7:    return a & ~b;
      4'd8:    return ~a | b;
      4'd9:    return ~(a ^ b);
      4'd10:   return b;
      4'd11:   return a & b;
      4'd12:   return 16'h0001;
      4'd13:   return a | ~b;
      4'd14:   return a | b;
      default: return a;
    endcase
  endfunction

  // Reference logic unit, combinational like the real one
  always_comb i_lu_result = lu_fn(o_lu_a, o_lu_b, o_lu_sel);

  function automatic logic [15:0] alu_ins(input logic [2:0] rd, input logic [3:0] sel,
                                          input logic [2:0] ra, input logic [2:0] rb);
    return {1'b0, rd, sel, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] li_ins(input logic [2:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 4'b0000, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge. With hold set, valid stays high with
  // nxt on the bus while the sequencer is busy.
  task automatic run_instr(input logic [15:0] ins, input logic hold, input logic [15:0] nxt);
    logic [15:0] expv;
    logic [2:0]  rd;
    int          lat;
    int          n;
    rd = ins[14:12];
    i_instr       = ins;
    i_instr_valid = 1'b1;
    i_dbg_addr    = rd;
    n = 0;
    while (!o_instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_transfer", {15'd0, o_instr_ready}, 16'd1);
    if (ins[15]) begin
      expv = {8'h00, ins[7:0]};
      lat  = 1;
    end else begin
      expv = lu_fn(model_rf[ins[7:5]], model_rf[ins[4:2]], ins[11:8]);
      lat  = 3;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) i_instr = nxt;
    else      i_instr_valid = 1'b0;
    if (!ins[15]) begin
      chk("issue_lu_a", o_lu_a, model_rf[ins[7:5]]);
      chk("issue_lu_b", o_lu_b, model_rf[ins[4:2]]);
      chk("issue_lu_sel", {12'd0, o_lu_sel}, {12'd0, ins[11:8]});
    end
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy_ready_low", {15'd0, o_instr_ready}, 16'd0);
      if (k < lat) chk("early_res_valid", {15'd0, o_res_valid}, 16'd0);
    end
    chk("res_valid", {15'd0, o_res_valid}, 16'd1);
    chk("res_data", o_res_data, expv);
    chk("res_rd", {13'd0, o_res_rd}, {13'd0, rd});
    chk("dbg_prewrite", o_dbg_data, model_rf[rd]);
    @(negedge clk);
    chk("res_valid_drop", {15'd0, o_res_valid}, 16'd0);
    chk("ready_return", {15'd0, o_instr_ready}, 16'd1);
    chk("res_data_hold", o_res_data, expv);
    chk("dbg_postwrite", o_dbg_data, expv);
    model_rf[rd] = expv;
  endtask

  task automatic check_rf_clear();
    for (int a = 0; a < 8; a++) begin
      i_dbg_addr = 3'(a);
      #1;
      chk($sformatf("dbg_zero_r%0d", a), o_dbg_data, 16'h0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rnd [41];
    rst_n         = 1'b0;
    i_instr       = '0;
    i_instr_valid = 1'b0;
    i_dbg_addr    = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_rf_clear();
    chk("reset_ready", {15'd0, o_instr_ready}, 16'd1);
    chk("reset_res_valid", {15'd0, o_res_valid}, 16'd0);
    chk("reset_lu_a", o_lu_a, 16'h0000);
    chk("reset_lu_sel", {12'd0, o_lu_sel}, 16'h0000);

    run_instr(li_ins(3'd1, 8'hA5), 1'b0, 16'h0);
    run_instr(li_ins(3'd2, 8'h3C), 1'b0, 16'h0);
    run_instr(alu_ins(3'd3, 4'd6, 3'd1, 3'd2), 1'b0, 16'h0);
    chk("xor_r3_value", model_rf[3], 16'h0099);
    run_instr(alu_ins(3'd4, 4'd12, 3'd1, 3'd2), 1'b0, 16'h0);
    run_instr(alu_ins(3'd5, 4'd3, 3'd1, 3'd2), 1'b0, 16'h0);
    run_instr(alu_ins(3'd6, 4'd0, 3'd1, 3'd2), 1'b0, 16'h0);
    i_dbg_addr = 3'd6;
    #1;
    chk("not_r1_in_r6", o_dbg_data, 16'hFF5A);

    // Same source/destination, with the next instruction waiting throughout
    run_instr(alu_ins(3'd1, 4'd0, 3'd1, 3'd1), 1'b1, li_ins(3'd7, 8'h5A));
    run_instr(li_ins(3'd7, 8'h5A), 1'b0, 16'h0);
    i_dbg_addr = 3'd1;
    #1;
    chk("r1_inverted", o_dbg_data, 16'hFF5A);

    for (int i = 0; i < 41; i++) rnd[i] = 16'($urandom);
    for (int i = 0; i < 40; i++)
      run_instr(rnd[i], 1'($urandom_range(0, 1)), rnd[i+1]);
    i_instr_valid = 1'b0;

    // Abort during CAPTURE
    run_instr(li_ins(3'd1, 8'hFF), 1'b0, 16'h0);
    i_instr       = alu_ins(3'd2, 4'd15, 3'd1, 3'd1);
    i_instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_instr_valid = 1'b0;
    chk("pre_abort_lu_a", o_lu_a, 16'h00FF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {15'd0, o_instr_ready}, 16'd1);
    chk("abort_res_valid", {15'd0, o_res_valid}, 16'd0);
    chk("abort_lu_a", o_lu_a, 16'h0000);
    chk("abort_lu_b", o_lu_b, 16'h0000);
    chk("abort_lu_sel", {12'd0, o_lu_sel}, 16'h0000);
    chk("abort_res_data", o_res_data, 16'h0000);
    chk("abort_res_rd", {13'd0, o_res_rd}, 16'h0000);
    check_rf_clear();
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_no_valid", {15'd0, o_res_valid}, 16'd0);
    end
    run_instr(alu_ins(3'd0, 4'd9, 3'd2, 3'd3), 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
